sw_debounce_conditioner: RTL and testbench

Conditions the board's 10 raw slide-switch/push-button lines before they reach the soft-core system's 10-bit input PIO (`pio_1_external_connection_export`). Each bit is synchronised into `clk_clk`, debounced with a per-bit stability counter, and presented as a clean level. One-cycle rise and fall strobes and an aggregate change strobe are also produced, for edge-sensitive logic or an interrupt-capable PIO. The block sits directly upstream of the core's input PIO in the top-level wrapper.

---
 rtl/sw_debounce_conditioner_if.sv | 27 ++
 rtl/sw_debounce_conditioner.sv | 104 ++++++++++
 tb/tb_sw_debounce_conditioner.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sw_debounce_conditioner_if.sv
// Switch conditioner signal bundle: raw levels in, debounced levels and strobes out.
// The DUT sits on the slave side; whoever drives the raw levels uses the master side.
interface sw_debounce_conditioner_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] sw_raw_in;
  logic [WIDTH-1:0] sw_clean_out;
  logic [WIDTH-1:0] sw_rise_pulse;
  logic [WIDTH-1:0] sw_fall_pulse;
  logic             sw_changed;

  modport master (
    output sw_raw_in,
    input  sw_clean_out,
    input  sw_rise_pulse,
    input  sw_fall_pulse,
    input  sw_changed
  );

  modport slave (
    input  sw_raw_in,
    output sw_clean_out,
    output sw_rise_pulse,
    output sw_fall_pulse,
    output sw_changed
  );
endinterface

// File: rtl/sw_debounce_conditioner.sv
// Per-bit synchroniser and stability-counter debouncer.
// Produces clean levels plus registered one-cycle rise, fall and any-change strobes.
//
// state   | meaning
// --------+-------------------------------------------------------------
// STABLE  | cnt == 0 and synchronised level matches the clean output
// PENDING | level differs (or just bounced back); counting toward commit
module sw_debounce_conditioner #(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  sw_debounce_conditioner_if.slave sw_if
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } bit_state_e;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_w;

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  bit_state_e       state_w [WIDTH];

  logic [WIDTH-1:0] clean_q, clean_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;

  assign sync_w = sync_q[SYNC_STAGES-1];

  // State is implied by the counter and the level compare; nothing extra is stored.
  always_comb begin
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i]   = cnt_q[i];
      state_w[i] = ((cnt_q[i] == '0) && (sync_w[i] == clean_q[i])) ? ST_STABLE : ST_PENDING;
      case (state_w[i])
        ST_STABLE: begin
          cnt_d[i] = '0;
        end
        ST_PENDING: begin
          if (sync_w[i] != clean_q[i]) begin
            if (cnt_q[i] == CNT_TERM) begin
              cnt_d[i]   = '0;
              clean_d[i] = sync_w[i];
              rise_d[i]  = sync_w[i];
              fall_d[i]  = ~sync_w[i];
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end else begin
            cnt_d[i] = '0;
          end
        end
      endcase
    end
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      clean_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      sync_q[0] <= sw_if.sw_raw_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      clean_q   <= clean_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign sw_if.sw_clean_out  = clean_q;
  assign sw_if.sw_rise_pulse = rise_q;
  assign sw_if.sw_fall_pulse = fall_q;
  assign sw_if.sw_changed    = changed_q;

endmodule

// File: tb/tb_sw_debounce_conditioner.sv
// Bench for sw_debounce_conditioner: directed test-plan steps plus random bouncing,
// all outputs compared every cycle against a sliding-window reference model.
module tb_sw_debounce_conditioner;

  localparam int W  = 10;
  localparam int S  = 2;
  localparam int D  = 8;
  localparam int HN = S + D;

  logic clk_clk = 1'b0;
  logic reset_reset = 1'b1;
  always #5 clk_clk = ~clk_clk;

  sw_debounce_conditioner_if #(.WIDTH(W)) sw_if ();

  sw_debounce_conditioner #(
    .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .sw_if       (sw_if.slave)
  );

  int total = 0;
  int bad   = 0;

  // Model: a level commits once the last D synchronised samples all disagree with it.
  logic [W-1:0] hist [HN];
  logic [W-1:0] m_clean, m_rise, m_fall;
  logic         m_chg;

  int pulses_any, rise5, fall5, chg_cnt;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [W-1:0] all1, any1;
    @(posedge clk_clk);
    if (reset_reset) begin
      for (int k = 0; k < HN; k++) hist[k] = '0;
      m_clean = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
    end else begin
      for (int k = HN - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = sw_if.sw_raw_in;
      all1 = '1;
      any1 = '0;
      for (int k = S; k < HN; k++) begin
        all1 &= hist[k];
        any1 |= hist[k];
      end
      m_rise  = ~m_clean & all1;
      m_fall  = m_clean & ~any1;
      m_clean = m_clean ^ (m_rise | m_fall);
      m_chg   = |(m_rise | m_fall);
    end
    #1;
    chk("model_clean", sw_if.sw_clean_out, m_clean);
    chk("model_rise", sw_if.sw_rise_pulse, m_rise);
    chk("model_fall", sw_if.sw_fall_pulse, m_fall);
    chk("model_changed", {9'd0, sw_if.sw_changed}, {9'd0, m_chg});
    pulses_any += $countones(sw_if.sw_rise_pulse | sw_if.sw_fall_pulse);
    rise5      += int'(sw_if.sw_rise_pulse[5]);
    fall5      += int'(sw_if.sw_fall_pulse[5]);
    chg_cnt    += int'(sw_if.sw_changed);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clr_counts();
    pulses_any = 0; rise5 = 0; fall5 = 0; chg_cnt = 0;
  endtask

  initial begin
    logic [W-1:0] r;
    for (int k = 0; k < HN; k++) hist[k] = '0;
    m_clean = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
    clr_counts();
    sw_if.sw_raw_in = '0;

    // Reset for 3 cycles
    reset_reset = 1'b1;
    steps(3);
    chk("reset_clean", sw_if.sw_clean_out, 10'h000);
    chk("reset_rise", sw_if.sw_rise_pulse, 10'h000);
    reset_reset = 1'b0;
    steps(2);

    // Clean step on bit 0
    clr_counts();
    sw_if.sw_raw_in[0] = 1'b1;
    steps(9);
    chk("step_pre_clean", sw_if.sw_clean_out, 10'h000);
    step();
    chk("step_clean", sw_if.sw_clean_out, 10'h001);
    chk("step_rise", sw_if.sw_rise_pulse, 10'h001);
    chk("step_changed", {9'd0, sw_if.sw_changed}, 10'h001);
    step();
    chk("step_rise_off", sw_if.sw_rise_pulse, 10'h000);
    chk("step_changed_off", {9'd0, sw_if.sw_changed}, 10'h000);
    chk("step_pulse_total", W'(pulses_any), 10'd1);

    // Glitch on bit 3 (5 cycles)
    clr_counts();
    sw_if.sw_raw_in[3] = 1'b1;
    steps(5);
    sw_if.sw_raw_in[3] = 1'b0;
    steps(15);
    chk("glitch_clean", sw_if.sw_clean_out, 10'h001);
    chk("glitch_pulses", W'(pulses_any), 10'd0);

    // Bounce on bit 5 (press, then release)
    clr_counts();
    sw_if.sw_raw_in[5] = 1'b1; steps(3);
    sw_if.sw_raw_in[5] = 1'b0; steps(3);
    sw_if.sw_raw_in[5] = 1'b1;
    steps(9);
    chk("bounce_pre_clean", sw_if.sw_clean_out, 10'h001);
    step();
    chk("bounce_clean", sw_if.sw_clean_out, 10'h021);
    steps(10);
    chk("bounce_rise_count", W'(rise5), 10'd1);
    clr_counts();
    sw_if.sw_raw_in[5] = 1'b0; steps(3);
    sw_if.sw_raw_in[5] = 1'b1; steps(3);
    sw_if.sw_raw_in[5] = 1'b0;
    steps(9);
    chk("release_pre_clean", sw_if.sw_clean_out, 10'h021);
    step();
    chk("release_clean", sw_if.sw_clean_out, 10'h001);
    steps(10);
    chk("release_fall_count", W'(fall5), 10'd1);

    // Simultaneous commits on bits 0,9 then bit 4
    sw_if.sw_raw_in = '0;
    steps(12);
    chk("simul_idle", sw_if.sw_clean_out, 10'h000);
    clr_counts();
    sw_if.sw_raw_in = 10'h201;
    steps(2);
    sw_if.sw_raw_in = 10'h211;
    steps(8);
    chk("simul_clean_a", sw_if.sw_clean_out, 10'h201);
    chk("simul_rise_a", sw_if.sw_rise_pulse, 10'h201);
    steps(2);
    chk("simul_clean_b", sw_if.sw_clean_out, 10'h211);
    chk("simul_rise_b", sw_if.sw_rise_pulse, 10'h010);
    steps(4);
    chk("simul_changed_count", W'(chg_cnt), 10'd2);

    // Reset mid-pending
    sw_if.sw_raw_in = 10'h3FF;
    steps(6);
    reset_reset = 1'b1;
    step();
    chk("rst_mid_clean", sw_if.sw_clean_out, 10'h000);
    step();
    chk("rst_mid_rise", sw_if.sw_rise_pulse, 10'h000);
    chk("rst_mid_changed", {9'd0, sw_if.sw_changed}, 10'h000);
    reset_reset = 1'b0;
    clr_counts();
    steps(9);
    chk("rst_pre_clean", sw_if.sw_clean_out, 10'h000);
    step();
    chk("rst_post_clean", sw_if.sw_clean_out, 10'h3FF);
    chk("rst_post_rise", sw_if.sw_rise_pulse, 10'h3FF);
    chk("rst_post_changed", {9'd0, sw_if.sw_changed}, 10'h001);
    step();
    chk("rst_post_changed_off", {9'd0, sw_if.sw_changed}, 10'h000);

    // Random bouncing with occasional resets, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      r = sw_if.sw_raw_in;
      if ((c / 100) % 2 == 0) begin
        for (int b = 0; b < W; b++)
          if ($urandom_range(0, 11) == 0) r[b] = ~r[b];
      end else if ($urandom_range(0, 39) == 0) begin
        r[$urandom_range(0, W - 1)] ^= 1'b1;
      end
      sw_if.sw_raw_in = r;
      reset_reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset_reset = 1'b0;
    steps(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
